// File: rtl/digitron_pkg.sv
// Shared constants for the six-digit display back end: digit count, clamp value,
// active-low a-g glyphs and the converter state encoding.
package digitron_pkg;

  localparam int          NUM_DIGITS = 6;
  localparam logic [19:0] MAX_VALUE  = 20'd999999;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } conv_state_t;

  function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [23:0] bcd_adjust(input logic [23:0] bcd);
    logic [23:0] res;
    res = bcd;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (res[4*n +: 4] >= 4'd5) res[4*n +: 4] = res[4*n +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/digitron_display_bin2bcd.sv
// Free-running sequential double-dabble: IDLE, LOAD, 20 x SHIFT, DONE = 23 cycles per result.
// Input is clamped to 999999 at LOAD; o_bcd and o_done update together one cycle after DONE.
module bin2bcd_seq
  import digitron_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [19:0] i_bin,
  output logic [23:0] o_bcd,
  output logic        o_done
);

  conv_state_t r_state;
  conv_state_t w_state_nxt;
  logic [19:0] r_bin;
  logic [23:0] r_scratch;
  logic [23:0] r_bcd;
  logic [4:0]  r_shift_cnt;
  logic        r_done;
  logic [43:0] w_shifted;

  assign w_shifted = {bcd_adjust(r_scratch), r_bin} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_shift_cnt == 5'd19) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin       <= '0;
      r_scratch   <= '0;
      r_bcd       <= '0;
      r_shift_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          r_bin       <= (i_bin > MAX_VALUE) ? MAX_VALUE : i_bin;
          r_scratch   <= '0;
          r_shift_cnt <= '0;
        end
        ST_SHIFT: begin
          {r_scratch, r_bin} <= w_shifted;
          r_shift_cnt        <= r_shift_cnt + 5'd1;
        end
        ST_DONE: begin
          r_bcd  <= r_scratch;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_bcd  = r_bcd;
  assign o_done = r_done;

endmodule

// File: rtl/digitron_display.sv
// Six-digit multiplexed 7-segment driver with leading-zero blanking, per-digit blink and DP.
// Outputs are registered one cycle behind the scan index; the first cycle of each slot is blank.
module digitron_display
  import digitron_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000,
  parameter bit LZ_BLANK  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] number_to_show,
  input  logic [5:0]  point_position,
  input  logic [5:0]  shank_position,
  output logic [7:0]  seg_n,
  output logic [5:0]  dig_sel_n,
  output logic        bcd_valid
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic [2:0]         r_dig_idx;
  logic [7:0]         r_seg_n;
  logic [5:0]         r_dig_sel_n;

  logic [23:0] w_bcd;
  logic [3:0]  w_nibs [NUM_DIGITS];
  logic [5:0]  w_lz;
  logic        w_blank;
  logic [7:0]  w_seg_nxt;
  logic [5:0]  w_dig_nxt;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (1'b1),
    .i_bin   (number_to_show),
    .o_bcd   (w_bcd),
    .o_done  (bcd_valid)
  );

  // w_lz[i]: digits 0..i are all zero
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) w_nibs[i] = w_bcd[(NUM_DIGITS-1-i)*4 +: 4];
    w_lz[0] = (w_nibs[0] == 4'd0);
    for (int i = 1; i < NUM_DIGITS; i++) w_lz[i] = w_lz[i-1] && (w_nibs[i] == 4'd0);
  end

  always_comb begin
    w_blank   = (r_blink_phase && shank_position[r_dig_idx]) ||
                (LZ_BLANK && (r_dig_idx != 3'd5) && w_lz[r_dig_idx]);
    w_seg_nxt = {~point_position[r_dig_idx],
                 w_blank ? SEG_BLANK : seg_pattern(w_nibs[r_dig_idx])};
    w_dig_nxt = ~(6'b1 << r_dig_idx);
    if (r_scan_cnt == '0) begin
      w_seg_nxt = 8'hFF;
      w_dig_nxt = 6'h3F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt    <= '0;
      r_dig_idx     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_seg_n       <= 8'hFF;
      r_dig_sel_n   <= 6'h3F;
    end else begin
      if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_dig_idx  <= (r_dig_idx == 3'd5) ? 3'd0 : r_dig_idx + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
      r_seg_n     <= w_seg_nxt;
      r_dig_sel_n <= w_dig_nxt;
    end
  end

  assign seg_n     = r_seg_n;
  assign dig_sel_n = r_dig_sel_n;

endmodule

// File: tb/tb_digitron_display.sv
// Randomised bench for digitron_display against a decimal-arithmetic display model.
module tb_digitron_display;
  import digitron_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] number_to_show = '0;
  logic [5:0]  point_position = '0;
  logic [5:0]  shank_position = '0;
  logic [7:0]  seg_n;
  logic [5:0]  dig_sel_n;
  logic        bcd_valid;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  digitron_display #(.SCAN_DIV(4), .BLINK_DIV(64), .LZ_BLANK(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .number_to_show (number_to_show),
    .point_position (point_position),
    .shank_position (shank_position),
    .seg_n          (seg_n),
    .dig_sel_n      (dig_sel_n),
    .bcd_valid      (bcd_valid)
  );

  always #5 clk = ~clk;

  // Edges since reset release; outputs sampled after edge k reflect scan state k-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  function automatic logic [6:0] ref_glyph(input int d);
    logic [6:0] on;
    case (d)
      0: on = 7'h3F; 1: on = 7'h06; 2: on = 7'h5B; 3: on = 7'h4F; 4: on = 7'h66;
      5: on = 7'h6D; 6: on = 7'h7D; 7: on = 7'h07; 8: on = 7'h7F; default: on = 7'h6F;
    endcase
    return ~on;
  endfunction

  function automatic int clampv(input int v);
    return (v > 999999) ? 999999 : v;
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    x = clampv(v);
    for (int j = 0; j < 6; j++) begin
      r[4*j +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] exp_dig(input int kk);
    int s;
    if (kk == 0) return 6'h3F;
    s = kk - 1;
    if (s % 4 == 0) return 6'h3F;
    return ~(6'b1 << ((s / 4) % 6));
  endfunction

  function automatic logic [7:0] exp_seg(input int kk, input int v, input logic [5:0] shk,
                                         input logic [5:0] pnt);
    int s, i, w, ph, x;
    logic [6:0] g;
    if (kk == 0) return 8'hFF;
    s = kk - 1;
    if (s % 4 == 0) return 8'hFF;
    i  = (s / 4) % 6;
    ph = (s / 64) % 2;
    x  = clampv(v);
    w  = 1;
    for (int j = 0; j < 5 - i; j++) w = w * 10;
    if (ph == 1 && shk[i])            g = 7'h7F;
    else if (i < 5 && (x / w) == 0)   g = 7'h7F;
    else                              g = ref_glyph((x / w) % 10);
    return {~pnt[i], g};
  endfunction

  task automatic test_reset();
    number_to_show = '0; point_position = '0; shank_position = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (seg_n !== 8'hFF)    begin bad++; $display("FAIL reset_seg got=%h exp=FF", seg_n); end
    total++; if (dig_sel_n !== 6'h3F) begin bad++; $display("FAIL reset_dig got=%h exp=3F", dig_sel_n); end
    total++; if (bcd_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b exp=0", bcd_valid); end
    total++; if (dut.w_bcd !== 24'h0) begin bad++; $display("FAIL reset_bcd got=%h exp=0", dut.w_bcd); end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      total++;
      if (dig_sel_n !== exp_dig(k) || seg_n !== exp_seg(k, 0, 6'h0, 6'h0)) begin
        bad++; $display("FAIL reset_scan k=%0d got=%h/%h exp=%h/%h", k, dig_sel_n, seg_n, exp_dig(k), exp_seg(k, 0, 6'h0, 6'h0));
      end
      if (k == 2) begin
        total++; if (dig_sel_n !== 6'h3E) begin bad++; $display("FAIL first_digit got=%h exp=3E", dig_sel_n); end
      end
    end
  endtask

  task automatic test_scan_123456();
    number_to_show = 20'd123456; point_position = '0; shank_position = '0;
    repeat (50) @(negedge clk);
    repeat (48) begin
      @(negedge clk);
      total++;
      if (dig_sel_n !== exp_dig(k) || seg_n !== exp_seg(k, 123456, 6'h0, 6'h0)) begin
        bad++; $display("FAIL scan123456 k=%0d got=%h/%h exp=%h/%h", k, dig_sel_n, seg_n, exp_dig(k), exp_seg(k, 123456, 6'h0, 6'h0));
      end
      if (exp_dig(k) == 6'h1F) begin
        total++; if (seg_n !== 8'h82) begin bad++; $display("FAIL digit5_six got=%h exp=82", seg_n); end
      end
    end
  endtask

  task automatic test_clamp();
    int v;
    for (int t = 0; t < 3; t++) begin
      v = (t == 0) ? 1000000 : int'($urandom_range(1048575, 1000000));
      number_to_show = 20'(v);
      repeat (50) @(negedge clk);
      total++; if (dut.w_bcd !== 24'h999999) begin bad++; $display("FAIL clamp_bcd v=%0d got=%h exp=999999", v, dut.w_bcd); end
      repeat (24) begin
        @(negedge clk);
        total++;
        if (dig_sel_n !== exp_dig(k) || seg_n !== exp_seg(k, v, 6'h0, 6'h0)) begin
          bad++; $display("FAIL clamp_scan k=%0d got=%h/%h exp=%h/%h", k, dig_sel_n, seg_n, exp_dig(k), exp_seg(k, v, 6'h0, 6'h0));
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    int vals [2];
    vals[0] = 42; vals[1] = 0;
    foreach (vals[n]) begin
      number_to_show = 20'(vals[n]);
      repeat (50) @(negedge clk);
      repeat (24) begin
        @(negedge clk);
        total++;
        if (dig_sel_n !== exp_dig(k) || seg_n !== exp_seg(k, vals[n], 6'h0, 6'h0)) begin
          bad++; $display("FAIL lz v=%0d k=%0d got=%h/%h exp=%h/%h", vals[n], k, dig_sel_n, seg_n, exp_dig(k), exp_seg(k, vals[n], 6'h0, 6'h0));
        end
      end
    end
  endtask

  task automatic test_blink_dp();
    number_to_show = 20'd123456; shank_position = 6'b000100; point_position = 6'b001000;
    repeat (50) @(negedge clk);
    repeat (200) begin
      @(negedge clk);
      total++;
      if (dig_sel_n !== exp_dig(k) || seg_n !== exp_seg(k, 123456, 6'b000100, 6'b001000)) begin
        bad++; $display("FAIL blink k=%0d got=%h/%h exp=%h/%h", k, dig_sel_n, seg_n, exp_dig(k), exp_seg(k, 123456, 6'b000100, 6'b001000));
      end
    end
  endtask

  task automatic test_random();
    int v;
    logic [5:0] shk, pnt;
    for (int t = 0; t < 8; t++) begin
      v   = (t % 2 == 0) ? int'($urandom_range(999, 0)) : int'($urandom_range(1048575, 0));
      shk = 6'($urandom);
      pnt = 6'($urandom);
      number_to_show = 20'(v); shank_position = shk; point_position = pnt;
      repeat (50) @(negedge clk);
      total++; if (dut.w_bcd !== to_bcd(v)) begin bad++; $display("FAIL rand_bcd v=%0d got=%h exp=%h", v, dut.w_bcd, to_bcd(v)); end
      repeat (72) begin
        @(negedge clk);
        total++;
        if (dig_sel_n !== exp_dig(k) || seg_n !== exp_seg(k, v, shk, pnt)) begin
          bad++; $display("FAIL rand_scan v=%0d k=%0d got=%h/%h exp=%h/%h", v, k, dig_sel_n, seg_n, exp_dig(k), exp_seg(k, v, shk, pnt));
        end
      end
    end
  endtask

  task automatic test_countdown();
    int cur, d, tick;
    logic ok, prev;
    logic [23:0] b;
    shank_position = '0; point_position = '0;
    cur = 305; number_to_show = 20'(cur);
    repeat (50) @(negedge clk);
    tick = 0; prev = 1'b0;
    while (cur > 0 || tick < 60) begin
      @(negedge clk);
      if (bcd_valid) begin
        b = dut.w_bcd; d = 0; ok = !prev;
        for (int j = 5; j >= 0; j--) begin
          if (b[4*j +: 4] > 4'd9) ok = 1'b0;
          d = d * 10 + int'(b[4*j +: 4]);
        end
        total++;
        if (!ok || d < cur || d > cur + 3) begin
          bad++; $display("FAIL countdown bcd=%h cur=%0d", b, cur);
        end
      end
      prev = bcd_valid;
      tick++;
      if (cur > 0 && tick == 10) begin
        cur--; number_to_show = 20'(cur); tick = 0;
      end
    end
    total++; if (dut.w_bcd !== 24'h0) begin bad++; $display("FAIL countdown_end got=%h exp=000000", dut.w_bcd); end
  endtask

  task automatic test_reset_mid();
    int n;
    number_to_show = 20'd777777;
    repeat (50) @(negedge clk);
    number_to_show = 20'd111111;
    n = 0;
    while (n < 40 && !(dut.u_conv.r_state == ST_SHIFT && dut.u_conv.r_shift_cnt == 5'd7)) begin
      @(negedge clk); n++;
    end
    total++; if (n >= 40) begin bad++; $display("FAIL wait_shift timeout got=%0d exp<40", n); end
    rst_n = 1'b0;
    #1;
    total++; if (seg_n !== 8'hFF)     begin bad++; $display("FAIL midrst_seg got=%h exp=FF", seg_n); end
    total++; if (dig_sel_n !== 6'h3F)  begin bad++; $display("FAIL midrst_dig got=%h exp=3F", dig_sel_n); end
    total++; if (dut.w_bcd !== 24'h0)  begin bad++; $display("FAIL midrst_bcd got=%h exp=0", dut.w_bcd); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 46 && bcd_valid !== 1'b1) begin
      @(negedge clk); n++;
      if (bcd_valid !== 1'b1) begin
        total++;
        if (dig_sel_n !== exp_dig(k) || seg_n !== exp_seg(k, 0, 6'h0, 6'h0)) begin
          bad++; $display("FAIL midrst_resume k=%0d got=%h/%h exp=%h/%h", k, dig_sel_n, seg_n, exp_dig(k), exp_seg(k, 0, 6'h0, 6'h0));
        end
      end
    end
    total++; if (bcd_valid !== 1'b1) begin bad++; $display("FAIL midrst_valid timeout got=%0d cycles exp<=46", n); end
    total++; if (dut.w_bcd !== 24'h111111) begin bad++; $display("FAIL midrst_newbcd got=%h exp=111111", dut.w_bcd); end
    repeat (24) begin
      @(negedge clk);
      total++;
      if (dig_sel_n !== exp_dig(k) || seg_n !== exp_seg(k, 111111, 6'h0, 6'h0)) begin
        bad++; $display("FAIL midrst_scan k=%0d got=%h/%h exp=%h/%h", k, dig_sel_n, seg_n, exp_dig(k), exp_seg(k, 111111, 6'h0, 6'h0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_123456();
    test_clamp();
    test_leading_zero();
    test_blink_dp();
    test_random();
    test_countdown();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
